// File: rtl/conv_result_serializer.sv
// conv_result_serializer
//   Captures one packed convolution result vector (L = N+M-1 words, word k at
//   in_data[k*DW +: DW]) and streams it out one word per beat, index 0 first.
//   Accept and emit never overlap: a frame costs at least L+1 cycles.
//
// Optional feature macro: CONV_SER_LAST_EN (adds out_last, high on the final
// word of each frame).
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input vector valid
//   in_ready   block can accept a vector (IDLE and not in reset)
//   in_data    packed result vector, L*DW bits
//   out_valid  out_data/out_index hold a valid word
//   out_ready  consumer accepts the word this cycle
//   out_data   current result word
//   out_index  index of out_data within its frame
//   frame_cnt  frames fully emitted since reset (wraps)
//   out_last   final word of the frame (CONV_SER_LAST_EN only)
module conv_result_serializer #(
    parameter int N  = 3,
    parameter int M  = 5,
    parameter int DW = 32,
    localparam int L  = N + M - 1,
    localparam int IW = (L > 1) ? $clog2(L) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [L*DW-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [IW-1:0]   out_index,
    output logic [15:0]     frame_cnt
`ifdef CONV_SER_LAST_EN
    ,
    output logic            out_last
`endif
);

    localparam logic [IW-1:0] LAST = IW'(L - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state, state_nx;
    logic [L-1:0][DW-1:0] buffer;
    logic                 accept;
    logic                 fire;
    logic                 fire_last;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and handshake decode
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        fire      = 1'b0;
        fire_last = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    accept   = 1'b1;
                    state_nx = SEND;
                end
            end
            SEND: begin
                // out_valid is high for the whole of SEND; data held while stalled
                if (out_ready) begin
                    fire = 1'b1;
                    if (out_index == LAST) begin
                        fire_last = 1'b1;
                        state_nx  = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: out_index doubles as the frame word pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            buffer    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            frame_cnt <= '0;
        end else if (accept) begin
            buffer    <= in_data;
            out_valid <= 1'b1;
            out_data  <= in_data[DW-1:0];
            out_index <= '0;
        end else if (fire_last) begin
            out_valid <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
        end else if (fire) begin
            out_index <= out_index + IW'(1);
            out_data  <= buffer[out_index + IW'(1)];
        end
    end

`ifdef CONV_SER_LAST_EN
    assign out_last = out_valid && (out_index == LAST);
`endif

endmodule

// File: tb/tb_conv_result_serializer.sv
// Bench for conv_result_serializer (N=3, M=5, DW=32). A table of frames with
// different backpressure modes is applied in a loop; expected words are pushed
// to a scoreboard queue when a frame is driven and compared when the DUT shows
// them. Hand-written sequences cover busy input and mid-frame reset.
module tb_conv_result_serializer;

    localparam int N  = 3;
    localparam int M  = 5;
    localparam int DW = 32;
    localparam int L  = N + M - 1;
    localparam int IW = $clog2(L);

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [L*DW-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_index;
    logic [15:0]     frame_cnt;
`ifdef CONV_SER_LAST_EN
    logic            out_last;
`endif

    conv_result_serializer #(.N(N), .M(M), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .frame_cnt (frame_cnt)
`ifdef CONV_SER_LAST_EN
        ,
        .out_last  (out_last)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [IW-1:0] i;
    } beat_t;

    typedef struct {
        logic [L*DW-1:0] data;
        int              mode;    // 0: always ready, 1: 1,0,0,1 pattern, 2: random
        logic [15:0]     exp_fc;  // frame_cnt after the frame drains
    } vec_t;

    beat_t q[$];
    int    vectors = 0;
    int    errs    = 0;
    int    cyc     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [L*DW-1:0] pack7(input logic [DW-1:0] w0, w1, w2, w3, w4, w5, w6);
        logic [L-1:0][DW-1:0] p;
        p[0] = w0; p[1] = w1; p[2] = w2; p[3] = w3; p[4] = w4; p[5] = w5; p[6] = w6;
        return p;
    endfunction

    task automatic push_frame(input logic [L*DW-1:0] data);
        beat_t b;
        for (int k = 0; k < L; k++) begin
            b.d = data[k*DW +: DW];
            b.i = IW'(k);
            q.push_back(b);
        end
    endtask

    function automatic logic ready_for(input int mode, input int c);
        logic [3:0] pat;
        pat = 4'b1001;
        case (mode)
            0:       return 1'b1;
            1:       return pat[c % 4];
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Scoreboard monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", {out_index, out_data}, 0);
            end else begin
                chk("out_data", out_data, q[0].d);
                chk("out_index", out_index, q[0].i);
`ifdef CONV_SER_LAST_EN
                chk("out_last", out_last, q[0].i == IW'(L - 1));
`endif
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 50) begin
            step();
            t++;
        end
        chk("in_ready_wait", in_ready, 1);
    endtask

    task automatic drain(input int mode);
        int t = 0;
        while (q.size() > 0 && t < 200) begin
            out_ready = ready_for(mode, t);
            step();
            t++;
        end
        chk("drain_timeout", q.size(), 0);
        out_ready = 1'b1;
    endtask

    task automatic send(input logic [L*DW-1:0] data, input int mode);
        wait_ready();
        push_frame(data);
        in_valid  = 1'b1;
        in_data   = data;
        out_ready = ready_for(mode, 0);
        step();
        in_valid = 1'b0;
        in_data  = '0;
        chk("first_valid_latency", out_valid, 1);
        drain(mode);
    endtask

    vec_t            tbl[5];
    logic [15:0]     exp_fc;
    logic [L*DW-1:0] basic, v2, v3;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset held for two cycles
        step();
        chk("rst_in_ready", in_ready, 0);
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready2", in_ready, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        basic = pack7(1, 3, 6, 9, 12, 9, 5);
        tbl[0] = '{basic, 0, 16'd1};
        tbl[1] = '{basic, 1, 16'd2};
        tbl[2] = '{pack7(32'hFFFF_FFFF, 32'h8000_0000, 0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1, 32'hDEAD_BEEF), 0, 16'd3};
        tbl[3] = '{pack7($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom), 2, 16'd4};
        tbl[4] = '{pack7(10, 20, 30, 40, 50, 60, 70), 2, 16'd5};

        for (int n = 0; n < 5; n++) begin
            send(tbl[n].data, tbl[n].mode);
            chk("end_out_valid", out_valid, 0);
            chk("frame_cnt", frame_cnt, tbl[n].exp_fc);
            chk("idle_in_ready", in_ready, 1);
        end
        exp_fc = 16'd5;

`ifdef CONV_SER_LAST_EN
        // Stall on the final beat: out_last must hold (checked by monitor)
        wait_ready();
        push_frame(basic);
        in_valid = 1'b1;
        in_data  = basic;
        step();
        in_valid = 1'b0;
        while (q.size() > 1) step();
        out_ready = 1'b0;
        step();
        step();
        chk("last_held", out_last, 1);
        out_ready = 1'b1;
        step();
        chk("last_clear", out_last, 0);
        exp_fc++;
        chk("frame_cnt_last", frame_cnt, exp_fc);
`endif

        // Busy input: vector 2 held on in_data during SEND must be ignored
        v2 = pack7(7, 8, 9, 10, 11, 12, 13);
        wait_ready();
        push_frame(basic);
        in_valid = 1'b1;
        in_data  = basic;
        step();
        in_data = v2;
        begin
            int t = 0;
            while (q.size() > 0 && t < 50) begin
                chk("busy_in_ready", in_ready, 0);
                step();
                t++;
            end
        end
        chk("busy_idle_ready", in_ready, 1);
        exp_fc++;
        chk("busy_frame_cnt", frame_cnt, exp_fc);
        push_frame(v2);
        step();
        in_valid = 1'b0;
        chk("v2_accepted", out_valid, 1);
        drain(1);
        exp_fc++;
        chk("v2_frame_cnt", frame_cnt, exp_fc);

        // Mid-frame reset after beat 3
        wait_ready();
        push_frame(basic);
        in_valid = 1'b1;
        in_data  = basic;
        step();
        in_valid = 1'b0;
        begin
            int t = 0;
            while (q.size() > L - 3 && t < 50) begin
                step();
                t++;
            end
        end
        rst = 1'b1;
        step();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_frame_cnt", frame_cnt, 0);
        chk("midrst_in_ready", in_ready, 0);
        q.delete();
        rst = 1'b0;
        v3 = pack7(100, 101, 102, 103, 104, 105, 106);
        send(v3, 0);
        chk("post_midrst_frame_cnt", frame_cnt, 1);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
